// File: rtl/dual_sng.sv
// Dual-channel stochastic number generator: converts two WIDTH-bit operands into 2^WIDTH-bit unary streams.
// Optional build macro DUAL_SNG_DECORR_EN: channel 1 compares against the non-reversed counter (decorrelated).
module dual_sng #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin0,
  input  logic [WIDTH-1:0] bin1,
  input  logic             hold,
  output logic             ready,
  output logic             out0,
  output logic             out1,
  output logic             out_valid,
  output logic             done
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_b0;
  logic [WIDTH-1:0] w_b0_nxt;
  logic [WIDTH-1:0] r_b1;
  logic [WIDTH-1:0] w_b1_nxt;

  logic             w_step;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_rng0;
  logic [WIDTH-1:0] w_rng1;

  // A stream bit is emitted whenever RUN is not stalled; the final position also frees the block.
  assign w_step   = (r_state == S_RUN) && !hold;
  assign w_last   = (r_cnt == CNT_MAX);
  assign w_ready  = (r_state == S_IDLE) || (w_step && w_last);
  assign w_accept = start && w_ready;

  // Bit-reversed counter gives a low-discrepancy sequence so each prefix stays well distributed.
  always_comb begin
    w_rng0 = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_rng0[i] = r_cnt[int'(WIDTH) - 1 - i];
    end
  end

`ifdef DUAL_SNG_DECORR_EN
  assign w_rng1 = r_cnt;
`else
  assign w_rng1 = w_rng0;
`endif

  // State register and operand/position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_b0    <= '0;
      r_b1    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_b0    <= w_b0_nxt;
      r_b1    <= w_b1_nxt;
    end
  end

  // Next-state: load on accept, advance on unstalled RUN, leave RUN only after the last position.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_b0_nxt    = r_b0;
    w_b1_nxt    = r_b1;
    if (w_accept) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = '0;
      w_b0_nxt    = bin0;
      w_b1_nxt    = bin1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_RUN: begin
          if (w_step) begin
            if (w_last) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + WIDTH'(1);
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign ready     = w_ready;
  assign out_valid = w_step;
  assign done      = w_step && w_last;
  assign out0      = (r_b0 > w_rng0) && w_step;
  assign out1      = (r_b1 > w_rng1) && w_step;

endmodule

// File: tb/tb_dual_sng.sv
// Scoreboard bench for dual_sng (WIDTH=4): directed scenarios plus randomized traffic.
module tb_dual_sng;

  localparam int unsigned W   = 4;
  localparam int          LEN = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] bin0;
  logic [W-1:0] bin1;
  logic         hold;
  logic         ready;
  logic         out0;
  logic         out1;
  logic         out_valid;
  logic         done;

  typedef struct packed {
    logic         o0;
    logic         o1;
    logic         dn;
    logic [W-1:0] b0;
    logic [W-1:0] b1;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   mdl_run = 0;
  int   mdl_pos = 0;
  int   ones0  = 0;
  int   ones1  = 0;

  dual_sng #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bin0      (bin0),
    .bin1      (bin1),
    .hold      (hold),
    .ready     (ready),
    .out0      (out0),
    .out1      (out1),
    .out_valid (out_valid),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int rev(int k);
    int r = 0;
    for (int i = 0; i < int'(W); i++) if (((k >> i) & 1) != 0) r += 1 << (int'(W) - 1 - i);
    return r;
  endfunction

  // Expected stream: channel 0 is 1 when operand exceeds the reversed position.
  function automatic void push_stream(logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    for (int k = 0; k < LEN; k++) begin
      e.o0 = (int'(a) > rev(k));
`ifdef DUAL_SNG_DECORR_EN
      e.o1 = (int'(b) > k);
`else
      e.o1 = (int'(b) > rev(k));
`endif
      e.dn = (k == LEN - 1);
      e.b0 = a;
      e.b1 = b;
      q.push_back(e);
    end
  endfunction

  // One clock of stimulus; called at posedge+1.
  task automatic step(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input bit h);
    bit exp_ready;
    start = s; bin0 = a; bin1 = b; hold = h;
    @(negedge clk);
    exp_ready = !mdl_run || (mdl_pos == LEN - 1 && !h);
    chk("ready", int'(ready), int'(exp_ready));
    chk("out_valid", int'(out_valid), int'(mdl_run && !h));
    if (s && exp_ready) begin
      push_stream(a, b);
      mdl_run = 1;
      mdl_pos = 0;
    end else if (mdl_run && !h) begin
      if (mdl_pos == LEN - 1) mdl_run = 0;
      else mdl_pos++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (mdl_run && n < 200) begin
      step(0, 4'(0), 4'(0), 0);
      n++;
    end
    chk("drain_bound", int'(mdl_run), 0);
  endtask

  task automatic do_reset();
    start = 0; hold = 0;
    rst_n = 0;
    #1;
    chk("rst_ready", int'(ready), 1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_out0", int'(out0), 0);
    chk("rst_out1", int'(out1), 0);
    chk("rst_done", int'(done), 0);
    q.delete();
    mdl_run = 0;
    mdl_pos = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected bit per valid cycle and checks stream ones counts at done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      ones0 = 0;
      ones1 = 0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("out0", int'(out0), int'(e.o0));
        chk("out1", int'(out1), int'(e.o1));
        chk("done", int'(done), int'(e.dn));
`ifndef DUAL_SNG_DECORR_EN
        if (e.b0 <= e.b1 && out0) chk("corr_out1", int'(out1), 1);
`endif
        ones0 += int'(out0);
        ones1 += int'(out1);
        if (e.dn) begin
          chk("ones0", ones0, int'(e.b0));
          chk("ones1", ones1, int'(e.b1));
          ones0 = 0;
          ones1 = 0;
        end
      end
    end else begin
      chk("idle_outs", int'({out0, out1, done}), 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; start = 0; hold = 0; bin0 = '0; bin1 = '0;
    #1;
    do_reset();

    // Basic 5/12 stream.
    step(1, 4'd5, 4'd12, 0);
    drain();

    // Back-to-back: start held high, operand 3 then 9.
    step(1, 4'd3, 4'd10, 0);
    for (int i = 0; i < LEN; i++) step(1, 4'd9, 4'd6, 0);
    drain();

    // Hold mid-stream for 3 cycles and at the final position.
    step(1, 4'd7, 4'd11, 0);
    repeat (4) step(0, 4'd0, 4'd0, 0);
    repeat (3) step(0, 4'd0, 4'd0, 1);
    while (mdl_run && mdl_pos < LEN - 1) step(0, 4'd0, 4'd0, 0);
    repeat (2) step(1, 4'd1, 4'd1, 1);
    step(0, 4'd0, 4'd0, 0);
    drain();

    // Bounds, plus a start at position 7 that must be ignored.
    step(1, 4'd0, 4'd15, 0);
    while (mdl_pos < 7) step(0, 4'd0, 4'd0, 0);
    step(1, 4'd8, 4'd2, 0);
    drain();

    // Reset mid-stream at position 6, then a fresh stream.
    step(1, 4'd13, 4'd4, 0);
    while (mdl_pos < 6) step(0, 4'd0, 4'd0, 0);
    do_reset();
    step(1, 4'd15, 4'd1, 0);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom), ($urandom_range(0, 4) == 0));
    end
    drain();

    repeat (3) step(0, 4'd0, 4'd0, 0);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_sng.md
DUAL_SNG -- requirements
Module: dual_sng

Interface
REQ-001 Parameter WIDTH, default 8, meaning binary operand width; stream length is 2^WIDTH cycles; legal range 2..16.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new conversion; accepted only when ready=1.
REQ-005 bin0  input  WIDTH  unsigned operand for channel 0; sampled on accepted start.
REQ-006 bin1  input  WIDTH  unsigned operand for channel 1; sampled on accepted start.
REQ-007 hold  input  1  stall; freezes stream position while high.
REQ-008 ready  output  1  high when a start is accepted this cycle.
REQ-009 out0  output  1  channel-0 unary bit; drives the downstream skew synchronizer in0.
REQ-010 out1  output  1  channel-1 unary bit; drives the downstream skew synchronizer in1.
REQ-011 out_valid  output  1  out0/out1 carry a stream bit this cycle.
REQ-012 done  output  1  single-cycle flag marking the last valid bit of a stream.

Function
REQ-013 The block SHALL have two states: IDLE and RUN.
REQ-014 On start=1 with ready=1 it SHALL latch bin0/bin1 into b0_q/b1_q, clear the WIDTH-bit position counter cnt, and enter RUN.
REQ-015 ready SHALL equal (state==IDLE) | (state==RUN & cnt==2^WIDTH-1 & hold==0).
REQ-016 start with ready=0 SHALL be ignored, with no effect on b0_q, b1_q, cnt or state.
REQ-017 out_valid SHALL equal (state==RUN & hold==0); the first valid bit appears the cycle after acceptance.
REQ-018 rng0 SHALL be bit-reverse(cnt); out0 SHALL be (b0_q > rng0) & out_valid.
REQ-019 rng1 SHALL be rng0 by default, giving maximally correlated streams; out1 SHALL be (b1_q > rng1) & out_valid.
REQ-020 Over one stream the number of 1s on out0 SHALL equal b0_q exactly; likewise out1 and b1_q (0 gives all zeros; 2^WIDTH-1 gives one zero).
REQ-021 In RUN with hold=0, cnt SHALL increment by 1 per cycle; with hold=1, cnt, outputs-source registers and state SHALL be frozen.
REQ-022 done SHALL be (state==RUN & cnt==2^WIDTH-1 & hold==0).
REQ-023 In the done cycle, without start the block SHALL return to IDLE; with start it SHALL reload operands, clear cnt and stay in RUN, giving gap-free back-to-back streams.
REQ-024 hold asserted in the final-position cycle SHALL defer done and ready until hold deasserts.
REQ-025 cnt wrap-around SHALL occur only through REQ-023, never as a free roll-over within RUN.
REQ-026 All outputs SHALL be combinational functions of registered state and of hold/start only, with no combinational path from bin0/bin1.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, cnt=0, b0_q=b1_q=0, which yields out0=out1=out_valid=done=0 and ready=1.
REQ-028 Reset asserted mid-stream SHALL abort the stream with no done pulse; the first start after release SHALL begin a fresh stream.

Configuration
REQ-029 Macro DUAL_SNG_DECORR_EN: when defined, rng1 SHALL be cnt (non-reversed), giving decorrelated channel-1 streams (channel 1 is thermometer-coded: b1_q ones first).
REQ-030 When DUAL_SNG_DECORR_EN is undefined, rng1 SHALL equal rng0; ones-count exactness (REQ-020) SHALL hold in both builds.

Verification (WIDTH=4)
REQ-031 Basic: start with bin0=5, bin1=12 -> 16 valid cycles, 5 ones on out0, 12 ones on out1, done on the 16th; out0 begins 1,0,1,0,1,0,0,0.
REQ-032 Correlation, default build: bin0=5, bin1=12 -> every cycle with out0=1 also has out1=1; DECORR_EN build -> out1=1 on exactly the first 12 valid cycles.
REQ-033 Back-to-back: start held high with bin0 3 then 9 -> 32 consecutive valid cycles, ones counts 3 then 9, done on cycles 16 and 32.
REQ-034 Hold: hold=1 for 3 cycles mid-stream and in the final cycle -> out_valid=0 during hold, total still 16 valid bits with correct counts, done deferred.
REQ-035 Bounds and ignore: bin0=0, bin1=15 -> 0 and 15 ones; start during RUN with cnt=7 -> ignored, operands unchanged.
REQ-036 Reset mid-stream at cnt=6 -> outputs 0 at once, ready=1, no done; the next stream is fully correct.
